// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: deserialises frames, strips F0/E0 prefixes and
// reports make/break strobes plus a held-key level on the system clock.
module ps2_scan_receiver #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       key_make,
  output logic       key_break,
  output logic       key_held,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state_q;
  logic        clkMeta_q, clkSync_q, clkPrev_q;
  logic        datMeta_q, datSync_q;
  logic [2:0]  bitCnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [TW-1:0] timer_q;
  logic        breakPend_q, extPend_q;
  logic [8:0]  heldCode_q;
  logic [7:0]  scanCode_q;
  logic        extended_q, keyMake_q, keyBreak_q, keyHeld_q, frameError_q;

  logic        fallEdge;
  logic        frameOk;
  logic [8:0]  codeWord;
  logic        isRepeat;

  assign fallEdge = clkPrev_q & ~clkSync_q;
  assign frameOk  = datSync_q & (^{shift_q, parity_q});
  assign codeWord = {extPend_q, shift_q};
  assign isRepeat = keyHeld_q && (codeWord == heldCode_q);

  // Synchroniser, frame FSM, timeout and prefix resolution share one register block
  // so the stop-bit edge resolves the byte and drives the outputs on the next cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clkMeta_q    <= 1'b1;
      clkSync_q    <= 1'b1;
      clkPrev_q    <= 1'b1;
      datMeta_q    <= 1'b1;
      datSync_q    <= 1'b1;
      state_q      <= IDLE;
      bitCnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      breakPend_q  <= 1'b0;
      extPend_q    <= 1'b0;
      heldCode_q   <= 9'h000;
      scanCode_q   <= 8'h00;
      extended_q   <= 1'b0;
      keyMake_q    <= 1'b0;
      keyBreak_q   <= 1'b0;
      keyHeld_q    <= 1'b0;
      frameError_q <= 1'b0;
    end else begin
      clkMeta_q    <= ps2_clk;
      clkSync_q    <= clkMeta_q;
      clkPrev_q    <= clkSync_q;
      datMeta_q    <= ps2_dat;
      datSync_q    <= datMeta_q;
      keyMake_q    <= 1'b0;
      keyBreak_q   <= 1'b0;
      frameError_q <= 1'b0;

      if (fallEdge) begin
        timer_q <= '0;
        case (state_q)
          IDLE: begin
            if (!datSync_q) begin
              state_q  <= DATA;
              bitCnt_q <= 3'd0;
            end
          end
          DATA: begin
            shift_q  <= {datSync_q, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= datSync_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q  <= IDLE;
            bitCnt_q <= 3'd0;
            if (!frameOk) begin
              frameError_q <= 1'b1;
              breakPend_q  <= 1'b0;
              extPend_q    <= 1'b0;
            end else if (shift_q == 8'hF0) begin
              breakPend_q <= 1'b1;
            end else if (shift_q == 8'hE0) begin
              extPend_q <= 1'b1;
            end else begin
              breakPend_q <= 1'b0;
              extPend_q   <= 1'b0;
              if (breakPend_q) begin
                scanCode_q <= shift_q;
                extended_q <= extPend_q;
                keyBreak_q <= 1'b1;
                if (codeWord == heldCode_q) keyHeld_q <= 1'b0;
              end else if (!isRepeat) begin
                // Typematic repeats of the held key are swallowed here.
                scanCode_q <= shift_q;
                extended_q <= extPend_q;
                keyMake_q  <= 1'b1;
                keyHeld_q  <= 1'b1;
                heldCode_q <= codeWord;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q      <= IDLE;
          bitCnt_q     <= 3'd0;
          timer_q      <= '0;
          frameError_q <= 1'b1;
          breakPend_q  <= 1'b0;
          extPend_q    <= 1'b0;
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  assign scan_code   = scanCode_q;
  assign extended    = extended_q;
  assign key_make    = keyMake_q;
  assign key_break   = keyBreak_q;
  assign key_held    = keyHeld_q;
  assign frame_error = frameError_q;

endmodule
